// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared state type and default constants for hs_req_ctrl
// No ports; imported by hs_req_ctrl.
package hs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } hs_state_e;

  localparam int HS_NCH         = 4;
  localparam int HS_SYNC_STAGES = 2;
  localparam int HS_PEND_W      = 3;
  localparam int HS_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/hs_sync_ndff.sv
// rtl/hs_sync_ndff.sv - N-flop synchronizer for a single asynchronous level
// Ports:
//   clk   : destination clock
//   reset : asynchronous active-high reset, clears every stage
//   d     : asynchronous input level
//   q     : synchronized level, STAGES clk edges after d
module hs_sync_ndff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/hs_req_ctrl.sv
// rtl/hs_req_ctrl.sv - per-channel four-phase req/ack handshake controller with event queueing
// Optional feature macro: HS_REQ_TIMEOUT_EN (per-channel REQ/REL timeout, sets err).
// Ports:
//   clk       : sole clock, rising edge
//   reset     : asynchronous active-high reset
//   in_pulse  : [NCH] single-cycle event request per channel
//   ack_async : [NCH] far-side ack level, asynchronous to clk
//   err_clr   : clears sticky ovf/err flags
//   req       : [NCH] request level to far side, registered
//   done      : [NCH] one-cycle pulse when a request is acknowledged
//   busy      : [NCH] channel not idle
//   pend_cnt  : [NCH*PEND_W] queued event count, channel i at [i*PEND_W +: PEND_W]
//   ovf       : [NCH] sticky pending-overflow flag
//   err       : [NCH] sticky timeout flag (constant 0 without HS_REQ_TIMEOUT_EN)
module hs_req_ctrl
  import hs_pkg::*;
#(
  parameter int NCH         = HS_NCH,
  parameter int SYNC_STAGES = HS_SYNC_STAGES,
  parameter int PEND_W      = HS_PEND_W,
  parameter int TIMEOUT_CYC = HS_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        in_pulse,
  input  logic [NCH-1:0]        ack_async,
  input  logic                  err_clr,
  output logic [NCH-1:0]        req,
  output logic [NCH-1:0]        done,
  output logic [NCH-1:0]        busy,
  output logic [NCH*PEND_W-1:0] pend_cnt,
  output logic [NCH-1:0]        ovf,
  output logic [NCH-1:0]        err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
`ifdef HS_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    hs_state_e         state_q, state_d;
    logic              ack_s;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              rel_exit;
`ifdef HS_REQ_TIMEOUT_EN
    logic              err_q, err_d;
    logic [TW-1:0]     tmo_q, tmo_d;
`endif

    hs_sync_ndff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (ack_async[i]),
      .q     (ack_s)
    );

    // REL is finishing this cycle; a coincident event is consumed by the
    // re-request instead of being queued.
    assign rel_exit = (state_q == ST_REL) && !ack_s;

    always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      pend_d  = pend_q;
      ovf_d   = ovf_q & ~err_clr;

      case (state_q)
        ST_IDLE: begin
          if (in_pulse[i]) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (ack_s) begin
            state_d = ST_REL;
            done_d  = 1'b1;
          end
        end
        ST_REL: begin
          if (!ack_s) begin
            if ((pend_q != '0) || in_pulse[i]) begin
              state_d = ST_REQ;
              // with a coincident event the dequeue and enqueue cancel
              if (!in_pulse[i]) pend_d = pend_q - 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (in_pulse[i] && (state_q != ST_IDLE) && !rel_exit) begin
        if (pend_q == PEND_MAX) ovf_d = 1'b1;  // saturate, event dropped
        else                    pend_d = pend_q + 1'b1;
      end

`ifdef HS_REQ_TIMEOUT_EN
      err_d = err_q & ~err_clr;
      tmo_d = '0;
      if ((state_q != ST_IDLE) && (state_d == state_q)) begin
        if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          pend_d  = '0;
          done_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`endif

      req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        req_q   <= 1'b0;
        done_q  <= 1'b0;
        ovf_q   <= 1'b0;
        pend_q  <= '0;
      end else begin
        state_q <= state_d;
        req_q   <= req_d;
        done_q  <= done_d;
        ovf_q   <= ovf_d;
        pend_q  <= pend_d;
      end
    end

`ifdef HS_REQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        err_q <= 1'b0;
        tmo_q <= '0;
      end else begin
        err_q <= err_d;
        tmo_q <= tmo_d;
      end
    end
    assign err[i] = err_q;
`else
    assign err[i] = 1'b0;
`endif

    assign req[i]                        = req_q;
    assign done[i]                       = done_q;
    assign busy[i]                       = (state_q != ST_IDLE);
    assign ovf[i]                        = ovf_q;
    assign pend_cnt[i*PEND_W +: PEND_W]  = pend_q;
  end

endmodule

// File: tb/tb_hs_req_ctrl.sv
// tb/tb_hs_req_ctrl.sv - directed self-checking bench for hs_req_ctrl
// Ports: none. Timeout checks are compiled when HS_REQ_TIMEOUT_EN is defined.
module tb_hs_req_ctrl;

  localparam int NCH = 4;
  localparam int PW  = 3;

  logic          clk;
  logic          reset;
  logic [NCH-1:0] in_pulse;
  logic [NCH-1:0] ack_async;
  logic          err_clr;
  logic [NCH-1:0] req, done, busy, ovf, err;
  logic [NCH*PW-1:0] pend_cnt;

  logic [NCH-1:0] far_en;
  logic [NCH-1:0] far_ack;
  logic [NCH-1:0] man_ack;
  int             far_cnt [NCH];
  int             done_cnt [NCH];

  integer checks   = 0;
  integer failures = 0;

  assign ack_async = far_ack | man_ack;

  hs_req_ctrl #(
    .NCH(NCH), .SYNC_STAGES(2), .PEND_W(PW), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset(reset), .in_pulse(in_pulse), .ack_async(ack_async),
    .err_clr(err_clr), .req(req), .done(done), .busy(busy),
    .pend_cnt(pend_cnt), .ovf(ovf), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // far side: raise ack 3 cycles after req rises, drop it once req is seen low
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (far_en[i] && req[i]) begin
        if (far_cnt[i] < 4) far_cnt[i] = far_cnt[i] + 1;
        if (far_cnt[i] >= 4) far_ack[i] = 1'b1;
      end else begin
        far_cnt[i] = 0;
        far_ack[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) if (done[i] === 1'b1) done_cnt[i] = done_cnt[i] + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pend(input int ch);
    logic [NCH*PW-1:0] v;
    v = pend_cnt;
    return v[ch*PW +: PW];
  endfunction

  // called just after an edge; leaves time just after the edge n cycles later
  task automatic pulse(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      in_pulse[ch] = 1'b1;
      @(posedge clk); #1;
    end
    in_pulse[ch] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_idle(input int ch, input int maxc, input string tag);
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (!busy[ch]) break;
    end
    check(tag, busy[ch], 0);
  endtask

  task automatic wait_done(input int ch, input int maxc, input string tag);
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (done[ch]) break;
    end
    check(tag, done[ch], 1);
  endtask

  int base;

  initial begin
    reset    = 1'b1;
    in_pulse = '0;
    err_clr  = 1'b0;
    far_en   = '1;
    far_ack  = '0;
    man_ack  = '0;
    for (int i = 0; i < NCH; i++) begin far_cnt[i] = 0; done_cnt[i] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", req, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_pend", pend_cnt, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1 reset = 1'b0;

    // basic: req high cycles 1..6, done in cycle 7, idle in cycle 10
    pulse(0, 1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check($sformatf("basic_req_c%0d", k), req[0], (k <= 6) ? 1 : 0);
      check($sformatf("basic_done_c%0d", k), done[0], (k == 7) ? 1 : 0);
      if (k == 9)  check("basic_busy_c9", busy[0], 1);
      if (k == 10) check("basic_busy_c10", busy[0], 0);
    end
    check("basic_pend", pend(0), 0);

    // queueing: 3 extra events during the first handshake
    @(posedge clk); #1;
    base = done_cnt[1];
    pulse(1, 4);
    @(negedge clk);
    check("queue_pend3", pend(1), 3);
    wait_idle(1, 200, "queue_idle");
    check("queue_done4", done_cnt[1] - base, 4);
    check("queue_pend0", pend(1), 0);
    check("queue_ovf", ovf[1], 0);

    // overflow: far side silent, 9 events while busy
    @(posedge clk); #1;
    far_en[2] = 1'b0;
    pulse(2, 1);
    pulse(2, 7);
    @(negedge clk);
    check("ovf_pend7", pend(2), 7);
    check("ovf_clear_before", ovf[2], 0);
    @(posedge clk); #1;
    pulse(2, 2);
    @(negedge clk);
    check("ovf_pend_sat", pend(2), 7);
    check("ovf_set", ovf[2], 1);
    @(posedge clk); #1;
    err_clr = 1'b1; in_pulse[2] = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0; in_pulse[2] = 1'b0;
    check("ovf_set_wins", ovf[2], 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("ovf_cleared", ovf[2], 0);
    check("ovf_req_held", req[2], 1);
    do_reset();
    far_en[2] = 1'b1;

    // simultaneous event on REL->REQ edge with pend_cnt=2
    pulse(3, 3);
    wait_done(3, 50, "sim_done1");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sim_rel_req", req[3], 0);
    check("sim_pend_before", pend(3), 2);
    in_pulse[3] = 1'b1;
    @(posedge clk); #1;
    in_pulse[3] = 1'b0;
    check("sim_req_again", req[3], 1);
    check("sim_pend_kept", pend(3), 2);
    wait_done(3, 50, "sim_done2");
    repeat (3) begin @(posedge clk); #1; end
    check("sim_pend_dec", pend(3), 1);
    wait_idle(3, 200, "sim_idle");

`ifdef HS_REQ_TIMEOUT_EN
    // timeout: ack never returns, 16 cycles in REQ
    do_reset();
    far_en[2] = 1'b0;
    base = done_cnt[2];
    pulse(2, 3);
    for (int k = 3; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) begin
        check("tmo_err_c16", err[2], 0);
        check("tmo_req_c16", req[2], 1);
      end
      if (k == 17) begin
        check("tmo_err_c17", err[2], 1);
        check("tmo_req_c17", req[2], 0);
        check("tmo_pend", pend(2), 0);
        check("tmo_busy", busy[2], 0);
      end
    end
    check("tmo_no_done", done_cnt[2] - base, 0);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("tmo_err_clr", err[2], 0);
    far_en[2] = 1'b1;
`else
    // without the timeout feature a stalled request stays up and err stays 0
    do_reset();
    far_en[2] = 1'b0;
    pulse(2, 1);
    repeat (40) @(negedge clk);
    check("notmo_req", req[2], 1);
    check("notmo_err", err, 0);
    far_en[2] = 1'b1;
    wait_idle(2, 50, "notmo_idle");
`endif

    // reset mid-handshake with ack held high
    do_reset();
    far_en[0] = 1'b0;
    pulse(0, 1);
    check("rstm_req_up", req[0], 1);
    man_ack[0] = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("rstm_req_drop", req[0], 0);
    check("rstm_busy", busy[0], 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    base = done_cnt[0];
    repeat (8) @(negedge clk);
    check("rstm_no_done", done_cnt[0] - base, 0);
    check("rstm_idle", busy[0], 0);
    check("rstm_req_low", req[0], 0);
    man_ack[0] = 1'b0;
    far_en[0]  = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/hs_req_ctrl.md
HS_REQ_CTRL -- requirements
Module: hs_req_ctrl

Interface
REQ-001 Parameter NCH, default 4, SHALL set the number of independent handshake channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the ack synchronizer depth (>=2).
REQ-003 Parameter PEND_W, default 3, SHALL set the pending-counter width; max pending = 2**PEND_W-1.
REQ-004 Parameter TIMEOUT_CYC, default 1024, SHALL set the timeout in clk cycles (used only with HS_REQ_TIMEOUT_EN).
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_pulse  input  NCH  per-channel single-cycle event request, clk domain.
REQ-008 ack_async  input  NCH  per-channel far-side ack level, asynchronous to clk.
REQ-009 err_clr  input  1  clears all sticky ovf/err flags.
REQ-010 req  output  NCH  per-channel request level to far side, driven directly from a flop.
REQ-011 done  output  NCH  one-cycle pulse per completed request (ack seen high).
REQ-012 busy  output  NCH  channel not IDLE.
REQ-013 pend_cnt  output  NCH*PEND_W  per-channel queued-event count, channel i at bits [i*PEND_W +: PEND_W].
REQ-014 ovf  output  NCH  sticky pending-overflow flag.
REQ-015 err  output  NCH  sticky timeout flag.

Function
REQ-016 Each channel SHALL run a 3-state FSM: IDLE (req=0), REQ (req=1, wait ack_s=1), REL (req=0, wait ack_s=0).
REQ-017 ack_s[i] SHALL be ack_async[i] through SYNC_STAGES flops; no other logic SHALL sample ack_async.
REQ-018 IDLE with in_pulse=1 SHALL enter REQ next edge; req rises 1 cycle after in_pulse.
REQ-019 REQ with ack_s=1 SHALL enter REL; req falls and done pulses on that same edge, for exactly 1 cycle.
REQ-020 REL with ack_s=0 SHALL enter REQ if pend_cnt>0 (decrementing it), else IDLE.
REQ-021 in_pulse while busy SHALL increment pend_cnt; at max it SHALL saturate and set ovf (event dropped).
REQ-022 in_pulse coincident with a REL->REQ decrement SHALL leave pend_cnt unchanged.
REQ-023 in_pulse in IDLE SHALL NOT touch pend_cnt.
REQ-024 err_clr SHALL clear ovf/err next edge; a simultaneous set event SHALL win.
REQ-025 Channels SHALL be fully independent; no arbitration or cross-channel ordering.

Reset
REQ-026 reset SHALL asynchronously force all FSMs to IDLE, synchronizers, pend_cnt, timeout counters to 0.
REQ-027 Reset values: req=0, done=0, busy=0, pend_cnt=0, ovf=0, err=0.
REQ-028 Reset mid-handshake SHALL drop req immediately; a still-high far-side ack SHALL not be counted as done after release (ack_s high in IDLE is ignored).

Configuration
REQ-029 With HS_REQ_TIMEOUT_EN defined, each channel SHALL count cycles spent in REQ or REL (cleared on state change); reaching TIMEOUT_CYC SHALL set err[i], force IDLE, clear pend_cnt[i], no done.
REQ-030 Without HS_REQ_TIMEOUT_EN, no timeout counters SHALL exist and err SHALL be constant 0.

Structure
REQ-031 Package hs_pkg SHALL hold the FSM state typedef (IDLE/REQ/REL) and the default parameter constants.
REQ-032 One sub-module hs_sync_ndff (parameter STAGES, active-high async reset) SHALL implement the ack synchronizer, instantiated per channel.

Verification
REQ-033 Basic: in_pulse[0] at cycle 0, far model returns ack 3 cycles after req -> req[0] high cycles 1..(1+3+2), done[0] one pulse, busy[0] low after ack drop seen.
REQ-034 Queueing: 3 in_pulse[1] during one handshake -> pend_cnt=3, then exactly 4 done pulses total, pend_cnt back to 0, ovf=0.
REQ-035 Overflow: PEND_W=3, 9 pulses while busy -> pend_cnt saturates at 7, ovf[i]=1, err_clr clears it.
REQ-036 Simultaneous: in_pulse on the REL->REQ edge with pend_cnt=2 -> pend_cnt stays 2.
REQ-037 Reset: assert reset while req=1 and ack high -> req=0 same cycle, no done after release.
REQ-038 Timeout (macro on, TIMEOUT_CYC=16): ack never returns -> err=1 at cycle 16 in REQ, req=0, pend_cnt=0, busy=0.
